// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion on
// stall or flush, and a saturating stall-cycle counter for performance debug.
module id_ex_stage #(
    parameter int WIDTH = 16,
    parameter int REGW  = 3,
    parameter int OPW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             valid_ID,
    input  logic [REGW-1:0]  read_reg1_ID,
    input  logic [REGW-1:0]  read_reg2_ID,
    input  logic             use_r1_ID,
    input  logic             use_r2_ID,
    input  logic [REGW-1:0]  w1_reg_ID,
    input  logic             reg_en_ID,
    input  logic             mem_en_ID,
    input  logic             mem_wr_ID,
    input  logic             b_sel_ID,
    input  logic [OPW-1:0]   alu_op_ID,
    input  logic [WIDTH-1:0] rs_ID,
    input  logic [WIDTH-1:0] rt_ID,
    input  logic [WIDTH-1:0] imm_ID,
    input  logic [WIDTH-1:0] pc_inc_ID,
    output logic [REGW-1:0]  read_reg1_ID_EX,
    output logic [REGW-1:0]  read_reg2_ID_EX,
    output logic [REGW-1:0]  w1_reg_ID_EX,
    output logic             reg_en_ID_EX,
    output logic             mem_en_ID_EX,
    output logic             mem_wr_ID_EX,
    output logic             b_sel_ID_EX,
    output logic             valid_ID_EX,
    output logic [OPW-1:0]   alu_op_ID_EX,
    output logic [WIDTH-1:0] rs_ID_EX,
    output logic [WIDTH-1:0] rt_ID_EX,
    output logic [WIDTH-1:0] imm_ID_EX,
    output logic [WIDTH-1:0] pc_inc_ID_EX,
    output logic             stall,
    output logic [15:0]      stall_count
);

    typedef enum logic {RUN, BUBBLE} state_t;

    typedef struct packed {
        logic             valid;
        logic             reg_en;
        logic             mem_en;
        logic             mem_wr;
        logic             b_sel;
        logic [OPW-1:0]   alu_op;
        logic [REGW-1:0]  rr1;
        logic [REGW-1:0]  rr2;
        logic [REGW-1:0]  w1;
        logic [WIDTH-1:0] rs;
        logic [WIDTH-1:0] rt;
        logic [WIDTH-1:0] imm;
        logic [WIDTH-1:0] pc_inc;
    } idex_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t      state_q;
    idex_t       idex_q, idex_d;
    logic [15:0] stall_count_q, stall_count_d;
    logic        ld_ex, haz;

    always_comb begin
        idex_d        = '0;
        idex_d.valid  = valid_ID;
        idex_d.reg_en = reg_en_ID;
        idex_d.mem_en = mem_en_ID;
        idex_d.mem_wr = mem_wr_ID;
        idex_d.b_sel  = b_sel_ID;
        idex_d.alu_op = alu_op_ID;
        idex_d.rr1    = read_reg1_ID;
        idex_d.rr2    = read_reg2_ID;
        idex_d.w1     = w1_reg_ID;
        idex_d.rs     = rs_ID;
        idex_d.rt     = rt_ID;
        idex_d.imm    = imm_ID;
        idex_d.pc_inc = pc_inc_ID;
    end

    // A bubble in ID/EX has valid=0, so the hazard term is naturally false in BUBBLE.
    assign ld_ex = idex_q.valid & idex_q.mem_en & ~idex_q.mem_wr & idex_q.reg_en;
    assign haz   = valid_ID & ld_ex &
                   ((use_r1_ID & (read_reg1_ID == idex_q.w1)) |
                    (use_r2_ID & (read_reg2_ID == idex_q.w1)));
    assign stall = haz & ~flush;

    assign stall_count_d = stall ? sat_inc(stall_count_q) : stall_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RUN;
            idex_q        <= '0;
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
            case (state_q)
                RUN: begin
                    if (flush || stall) begin
                        idex_q  <= '0;
                        state_q <= BUBBLE;
                    end else begin
                        idex_q  <= idex_d;
                    end
                end
                BUBBLE: begin
                    if (flush) begin
                        idex_q  <= '0;
                    end else begin
                        idex_q  <= idex_d;
                        state_q <= RUN;
                    end
                end
                default: begin
                    idex_q  <= '0;
                    state_q <= RUN;
                end
            endcase
        end
    end

    assign read_reg1_ID_EX = idex_q.rr1;
    assign read_reg2_ID_EX = idex_q.rr2;
    assign w1_reg_ID_EX    = idex_q.w1;
    assign reg_en_ID_EX    = idex_q.reg_en;
    assign mem_en_ID_EX    = idex_q.mem_en;
    assign mem_wr_ID_EX    = idex_q.mem_wr;
    assign b_sel_ID_EX     = idex_q.b_sel;
    assign valid_ID_EX     = idex_q.valid;
    assign alu_op_ID_EX    = idex_q.alu_op;
    assign rs_ID_EX        = idex_q.rs;
    assign rt_ID_EX        = idex_q.rt;
    assign imm_ID_EX       = idex_q.imm;
    assign pc_inc_ID_EX    = idex_q.pc_inc;
    assign stall_count     = stall_count_q;

endmodule
